// File: rtl/osc_meas_pkg.sv
// Shared definitions for the oscillator period measurement controller:
// FSM state type, default parameter values and the counter saturation helper.
package osc_meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_ARM     = 3'd2,
        ST_MEASURE = 3'd3,
        ST_DONE    = 3'd4
    } osc_state_e;

    localparam int unsigned OSC_CNT_W_DEF     = 8;
    localparam int unsigned OSC_NAVG_LOG2_DEF = 2;
    localparam int unsigned OSC_ACC_W_DEF     = 16;

    // Largest value a w-bit period counter can hold.
    function automatic int unsigned sat_count(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/trig_edge_det.sv
// Brings the asynchronous oscillator output into the clk domain and emits a
// one-cycle pulse per rising edge, three clk cycles after the raw edge.
module trig_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic trigger,
    output logic trig_edge
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Two-flop synchronizer, one history flop, registered rising-edge pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
            trig_edge <= 1'b0;
        end else begin
            sync1     <= trigger;
            sync2     <= sync1;
            sync3     <= sync2;
            trig_edge <= sync2 & ~sync3;
        end
    end

endmodule

// File: rtl/osc_meas_ctrl.sv
// Oscillator period measurement sequencer: enable oscillator, settle, time
// 2^NAVG_LOG2 trigger periods, present the average on a valid/ready port.
// Optional build macro OSC_MEAS_CTRL_CONTINUOUS_EN: a DONE handshake with
// start=1 re-arms directly without dropping osc_en or re-settling.
module osc_meas_ctrl
    import osc_meas_pkg::*;
#(
    parameter int unsigned CNT_W     = OSC_CNT_W_DEF,
    parameter int unsigned NAVG_LOG2 = OSC_NAVG_LOG2_DEF,
    parameter int unsigned ACC_W     = OSC_ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       settle_cycles,
    input  logic             trigger,
    output logic             osc_en,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             timeout_err
);

    if (ACC_W < CNT_W + NAVG_LOG2) begin : g_acc_w_check
        $error("osc_meas_ctrl: ACC_W must be >= CNT_W + NAVG_LOG2");
    end

    localparam logic [CNT_W-1:0]   CNT_SAT   = CNT_W'(sat_count(CNT_W));
    localparam logic [NAVG_LOG2:0] NAVG_LAST = (NAVG_LOG2 + 1)'((1 << NAVG_LOG2) - 1);

    // In continuous builds the oscillator is left running through DONE so a
    // back-to-back measurement can re-arm without a settle; it is shut off
    // when the handshake returns to IDLE instead.
`ifdef OSC_MEAS_CTRL_CONTINUOUS_EN
    localparam logic DONE_OSC_EN = 1'b1;
`else
    localparam logic DONE_OSC_EN = 1'b0;
`endif

    osc_state_e         state;
    logic [7:0]         settle_tgt;
    logic [7:0]         settle_cnt;
    logic [CNT_W-1:0]   period_cnt;
    logic [ACC_W-1:0]   acc;
    logic [NAVG_LOG2:0] periods_done;
    logic               trig_edge;
    logic [ACC_W-1:0]   acc_sum;
    logic [ACC_W-1:0]   acc_avg;

    trig_edge_det u_trig_edge_det (
        .clk       (clk),
        .rst       (rst),
        .trigger   (trigger),
        .trig_edge (trig_edge)
    );

    assign busy = (state != ST_IDLE);

    // Running sum including the period that closes on this cycle's edge.
    // period_cnt already equals the cycle distance to the previous edge.
    always_comb begin
        acc_sum = acc + ACC_W'(period_cnt);
        acc_avg = acc_sum >> NAVG_LOG2;
    end

    // Measurement FSM, counters, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            settle_tgt   <= '0;
            settle_cnt   <= '0;
            period_cnt   <= '0;
            acc          <= '0;
            periods_done <= '0;
            osc_en       <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_SETTLE;
                        osc_en       <= 1'b1;
                        settle_tgt   <= settle_cycles;
                        settle_cnt   <= 8'd1;
                        period_cnt   <= '0;
                        acc          <= '0;
                        periods_done <= '0;
                    end
                end
                ST_SETTLE: begin
                    // settle_cnt starts at 1, so a target of 0 or 1 both leave after one cycle
                    if (settle_cnt >= settle_tgt) begin
                        state      <= ST_ARM;
                        period_cnt <= CNT_W'(1);
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                ST_ARM: begin
                    if (trig_edge) begin
                        state      <= ST_MEASURE;
                        period_cnt <= CNT_W'(1);
                    end else if (period_cnt == CNT_SAT) begin
                        state        <= ST_DONE;
                        osc_en       <= DONE_OSC_EN;
                        result       <= '1;
                        timeout_err  <= 1'b1;
                        result_valid <= 1'b1;
                    end else begin
                        period_cnt <= period_cnt + CNT_W'(1);
                    end
                end
                ST_MEASURE: begin
                    // An edge on the saturation cycle still closes a valid period.
                    if (trig_edge) begin
                        acc          <= acc_sum;
                        periods_done <= periods_done + (NAVG_LOG2 + 1)'(1);
                        period_cnt   <= CNT_W'(1);
                        if (periods_done == NAVG_LAST) begin
                            state        <= ST_DONE;
                            osc_en       <= DONE_OSC_EN;
                            result       <= (|acc_avg[ACC_W-1:CNT_W]) ? '1 : acc_avg[CNT_W-1:0];
                            timeout_err  <= 1'b0;
                            result_valid <= 1'b1;
                        end
                    end else if (period_cnt == CNT_SAT) begin
                        state        <= ST_DONE;
                        osc_en       <= DONE_OSC_EN;
                        result       <= '1;
                        timeout_err  <= 1'b1;
                        result_valid <= 1'b1;
                    end else begin
                        period_cnt <= period_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (result_valid && result_ready) begin
                        result_valid <= 1'b0;
`ifdef OSC_MEAS_CTRL_CONTINUOUS_EN
                        if (start) begin
                            state        <= ST_ARM;
                            period_cnt   <= CNT_W'(1);
                            acc          <= '0;
                            periods_done <= '0;
                        end else begin
                            state  <= ST_IDLE;
                            osc_en <= 1'b0;
                        end
`else
                        state  <= ST_IDLE;
                        osc_en <= 1'b0;
`endif
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    osc_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_osc_meas_ctrl.sv
// Scoreboard bench for osc_meas_ctrl: stimulus pushes the expected result
// computed from the gap list, a forked monitor pops it on each handshake.
module tb_osc_meas_ctrl;

    typedef struct packed {
        logic [7:0] res;
        logic       to;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] settle_cycles = 8'd0;
    logic       trigger = 1'b0;
    logic       osc_en;
    logic       busy;
    logic [7:0] result;
    logic       result_valid;
    logic       result_ready = 1'b0;
    logic       timeout_err;

    int   passed = 0;
    int   total = 0;
    exp_t exp_q[$];

    osc_meas_ctrl #(.CNT_W(8), .NAVG_LOG2(2), .ACC_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .settle_cycles (settle_cycles),
        .trigger       (trigger),
        .osc_en        (osc_en),
        .busy          (busy),
        .result        (result),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Reference: average of the first four gaps, timeout if the first edge
    // never comes or any needed gap is missing or longer than 255 cycles.
    function automatic exp_t model(input bit first_edge, input int gaps[$]);
        exp_t e;
        int   sum;
        sum = 0;
        e.res = 8'hFF;
        e.to  = 1'b1;
        if (!first_edge) return e;
        for (int i = 0; i < 4; i++) begin
            if (i >= gaps.size() || gaps[i] > 255) return e;
            sum += gaps[i];
        end
        e.res = 8'(sum / 4);
        e.to  = 1'b0;
        return e;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && result_valid && result_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", {24'd0, result}, {24'd0, e.res});
                    chk("timeout_err", {31'd0, timeout_err}, {31'd0, e.to});
                end
            end
        end
    endtask

    task automatic rise();
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
    endtask

    task automatic drive_edges(input bit first_edge, input int gaps[$], input bit poke);
        if (!first_edge) return;
        rise();
        for (int i = 0; i < gaps.size(); i++) begin
            if (gaps[i] > 255) return;
            if (poke && i == 1 && gaps[i] >= 3) begin
                start = 1'b1;
                tick(1);
                start = 1'b0;
                tick(gaps[i] - 2);
            end else begin
                tick(gaps[i] - 1);
            end
            rise();
        end
    endtask

    task automatic begin_meas(input int settle);
        chk("osc_en_idle", {31'd0, osc_en}, 0);
        settle_cycles = 8'(settle);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("osc_en_rise", {31'd0, osc_en}, 1);
        chk("busy_rise", {31'd0, busy}, 1);
        tick(((settle > 1) ? settle : 1) + 3);
    endtask

    task automatic finish_meas(input int hold, input bit hs_start);
        int         n;
        logic [7:0] r0;
        logic       t0;
        bit         stable;
        n = 0;
        while (!result_valid && n < 700) begin
            tick(1);
            n++;
        end
        if (!result_valid) begin
            chk("valid_wait", 0, 1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            rst = 1'b1;
            tick(1);
            rst = 1'b0;
            return;
        end
`ifdef OSC_MEAS_CTRL_CONTINUOUS_EN
        chk("osc_en_done", {31'd0, osc_en}, 1);
`else
        chk("osc_en_done", {31'd0, osc_en}, 0);
`endif
        r0 = result;
        t0 = timeout_err;
        stable = 1'b1;
        repeat (hold) begin
            tick(1);
            if (result !== r0 || timeout_err !== t0 || result_valid !== 1'b1) stable = 1'b0;
        end
        if (hold > 0) chk("hold_stable", {31'd0, stable}, 1);
        result_ready = 1'b1;
        start = hs_start;
        tick(1);
        result_ready = 1'b0;
        start = 1'b0;
        chk("valid_drop", {31'd0, result_valid}, 0);
        chk("result_hold", {23'd0, timeout_err, result}, {23'd0, t0, r0});
`ifdef OSC_MEAS_CTRL_CONTINUOUS_EN
        chk("busy_after_hs", {31'd0, busy}, {31'd0, hs_start});
        chk("osc_en_after_hs", {31'd0, osc_en}, {31'd0, hs_start});
`else
        chk("busy_after_hs", {31'd0, busy}, 0);
`endif
    endtask

    task automatic run_meas(input int settle, input bit first_edge, input int gaps[$],
                            input int hold, input bit poke);
        exp_q.push_back(model(first_edge, gaps));
        begin_meas(settle);
        drive_edges(first_edge, gaps, poke);
        finish_meas(hold, 1'b0);
    endtask

    initial begin
        int g[$];
        int n;
        fork
            monitor();
        join_none

        tick(3);
        chk("rst_osc_en", {31'd0, osc_en}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_valid", {31'd0, result_valid}, 0);
        chk("rst_result", {24'd0, result}, 0);
        chk("rst_timeout", {31'd0, timeout_err}, 0);
        rst = 1'b0;
        tick(2);

        // result_ready while idle must not disturb anything
        result_ready = 1'b1;
        tick(2);
        result_ready = 1'b0;
        chk("ready_idle", {30'd0, busy, result_valid}, 0);

        g = '{10, 10, 10, 10};
        run_meas(5, 1'b1, g, 20, 1'b1);
        g = '{9, 10, 11, 12};
        run_meas(0, 1'b1, g, 2, 1'b0);
        g = {};
        run_meas(2, 1'b0, g, 1, 1'b0);
        g = '{20, 300};
        run_meas(3, 1'b1, g, 0, 1'b0);
        g = '{255, 255, 255, 255};
        run_meas(1, 1'b1, g, 0, 1'b0);
        g = '{2, 2, 2, 3};
        run_meas(4, 1'b1, g, 3, 1'b0);
        g = '{255, 256};
        run_meas(0, 1'b1, g, 0, 1'b0);

        // reset in the middle of MEASURE
        settle_cycles = 8'd2;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(5);
        rise();
        tick(9);
        rise();
        tick(6);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_osc_en", {31'd0, osc_en}, 0);
        chk("midrst_valid", {31'd0, result_valid}, 0);
        tick(3);

        // start held at the handshake
        g = '{7, 8, 9, 10};
        exp_q.push_back(model(1'b1, g));
        begin_meas(1);
        drive_edges(1'b1, g, 1'b0);
        finish_meas(2, 1'b1);
`ifdef OSC_MEAS_CTRL_CONTINUOUS_EN
        g = '{15, 16, 17, 21};
        exp_q.push_back(model(1'b1, g));
        tick(3);
        drive_edges(1'b1, g, 1'b0);
        finish_meas(1, 1'b0);
`endif
        tick(3);

        for (int t = 0; t < 15; t++) begin
            g = {};
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 15) == 0) g.push_back(int'($urandom_range(256, 270)));
                else g.push_back(int'($urandom_range(2, 60)));
            end
            run_meas(int'($urandom_range(0, 12)), 1'b1, g, int'($urandom_range(0, 5)),
                     ($urandom_range(0, 3) == 0));
            tick(int'($urandom_range(1, 4)));
        end

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick(1);
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
